// File: rtl/gb_statemanager_rewind.sv
// gb_statemanager_rewind
//   Rewind ring-buffer and manual savestate sequencer for the GB core.
//   Every FRAME_DIV frames it either captures a state image into the ring
//   (normal play) or loads the most recent ring image back (while rewinding).
//   Manual save/load pulses target fixed savestate slots and take priority.
//
// Ports
//   clk, reset                sole clock, synchronous active-high reset
//   rewind_on / rewind_active  user rewind request in / registered mode out
//   savestate_number          manual slot select, sampled at save/load pulse
//   save, load                one-cycle manual request pulses
//   sleep_rewind              core pause request (mirrors rewind_active)
//   vsync                     frame sync; rising edge is a frame tick
//   request_savestate/_loadstate/_address   transaction request to state engine
//   request_busy              state engine busy handshake
module gb_statemanager_rewind #(
    parameter int unsigned REWIND_DEPTH = 48,
    parameter int unsigned SLOT_SIZE    = 1048576,
    parameter int unsigned REWIND_ADDR  = 33554432,
    parameter int unsigned SAVE_ADDR    = 16777216,
    parameter int unsigned FRAME_DIV    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rewind_on,
    output logic        rewind_active,
    input  logic [1:0]  savestate_number,
    input  logic        save,
    input  logic        load,
    output logic        sleep_rewind,
    input  logic        vsync,
    output logic        request_savestate,
    output logic        request_loadstate,
    output logic [31:0] request_address,
    input  logic        request_busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DONE} state_t;
    typedef enum logic [1:0] {J_SAVE, J_LOAD, J_CAP, J_STEP} job_t;

    localparam logic [7:0] DEPTH    = 8'(REWIND_DEPTH);
    localparam logic [7:0] DEPTH_M1 = 8'(REWIND_DEPTH - 1);
    localparam logic [7:0] FDIV_M1  = 8'(FRAME_DIV - 1);

    state_t      state_q, state_d;
    job_t        job_q, job_d;
    logic        vsync_q, vsync_prev_q;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        pend_save_q, pend_save_d, pend_load_q, pend_load_d;
    logic [1:0]  save_num_q, save_num_d, load_num_q, load_num_d;
    logic [7:0]  wr_ptr_q, wr_ptr_d, count_q, count_d;
    logic        rewind_active_q;
    logic        req_save_q, req_save_d, req_load_q, req_load_d;
    logic [31:0] req_addr_q, req_addr_d;

    logic        tick, interval;
    logic        take_save, take_load;
    logic [7:0]  ptr_inc, ptr_dec;

    function automatic logic [31:0] ring_addr(input logic [7:0] idx);
        return 32'(REWIND_ADDR) + 32'(idx) * 32'(SLOT_SIZE);
    endfunction

    function automatic logic [31:0] slot_addr(input logic [1:0] num);
        return 32'(SAVE_ADDR) + 32'(num) * 32'(SLOT_SIZE);
    endfunction

    assign tick     = vsync_q & ~vsync_prev_q;
    assign interval = tick && (frame_cnt_q == FDIV_M1);
    assign ptr_inc  = (wr_ptr_q == DEPTH_M1) ? 8'd0 : wr_ptr_q + 8'd1;
    assign ptr_dec  = (wr_ptr_q == 8'd0) ? DEPTH_M1 : wr_ptr_q - 8'd1;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (tick) frame_cnt_d = (frame_cnt_q == FDIV_M1) ? 8'd0 : frame_cnt_q + 8'd1;
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        req_save_d = req_save_q;
        req_load_d = req_load_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        take_save  = 1'b0;
        take_load  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Interval events that lose to a manual job are simply dropped.
                if (pend_save_q) begin
                    take_save  = 1'b1;
                    job_d      = J_SAVE;
                    req_save_d = 1'b1;
                    req_addr_d = slot_addr(save_num_q);
                    state_d    = S_REQ;
                end else if (pend_load_q) begin
                    take_load  = 1'b1;
                    job_d      = J_LOAD;
                    req_load_d = 1'b1;
                    req_addr_d = slot_addr(load_num_q);
                    state_d    = S_REQ;
                end else if (interval && rewind_active_q && count_q != 8'd0) begin
                    job_d      = J_STEP;
                    req_load_d = 1'b1;
                    req_addr_d = ring_addr(ptr_dec);
                    state_d    = S_REQ;
                end else if (interval && !rewind_active_q) begin
                    job_d      = J_CAP;
                    req_save_d = 1'b1;
                    req_addr_d = ring_addr(wr_ptr_q);
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (request_busy) begin
                    req_save_d = 1'b0;
                    req_load_d = 1'b0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Pointer bookkeeping is committed only when the job completes,
                // so a rewind release mid-job still applies its update.
                if (!request_busy) begin
                    state_d = S_IDLE;
                    unique case (job_q)
                        J_CAP: begin
                            wr_ptr_d = ptr_inc;
                            count_d  = (count_q == DEPTH) ? count_q : count_q + 8'd1;
                        end
                        J_STEP: begin
                            wr_ptr_d = ptr_dec;
                            count_d  = count_q - 8'd1;
                        end
                        J_LOAD:  count_d = 8'd0;
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending flags merge repeated pulses; load loses to a simultaneous save.
    always_comb begin
        pend_save_d = (pend_save_q & ~take_save) | save;
        pend_load_d = (pend_load_q & ~take_load) | (load & ~save);
        save_num_d  = save ? savestate_number : save_num_q;
        load_num_d  = (load && !save) ? savestate_number : load_num_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            job_q           <= J_SAVE;
            vsync_q         <= 1'b0;
            vsync_prev_q    <= 1'b0;
            frame_cnt_q     <= 8'd0;
            pend_save_q     <= 1'b0;
            pend_load_q     <= 1'b0;
            save_num_q      <= 2'd0;
            load_num_q      <= 2'd0;
            wr_ptr_q        <= 8'd0;
            count_q         <= 8'd0;
            rewind_active_q <= 1'b0;
            req_save_q      <= 1'b0;
            req_load_q      <= 1'b0;
            req_addr_q      <= 32'd0;
        end else begin
            state_q         <= state_d;
            job_q           <= job_d;
            vsync_q         <= vsync;
            vsync_prev_q    <= vsync_q;
            frame_cnt_q     <= frame_cnt_d;
            pend_save_q     <= pend_save_d;
            pend_load_q     <= pend_load_d;
            save_num_q      <= save_num_d;
            load_num_q      <= load_num_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            rewind_active_q <= rewind_on;
            req_save_q      <= req_save_d;
            req_load_q      <= req_load_d;
            req_addr_q      <= req_addr_d;
        end
    end

    assign rewind_active     = rewind_active_q;
    assign sleep_rewind      = rewind_active_q;
    assign request_savestate = req_save_q;
    assign request_loadstate = req_load_q;
    assign request_address   = req_addr_q;

endmodule

// File: tb/tb_gb_statemanager_rewind.sv
// Scoreboard bench: stimulus pushes expected {is_load, address} entries,
// a negedge monitor pops and compares on every new request.
module tb_gb_statemanager_rewind;

    logic        clk = 1'b0;
    logic        reset, rewind_on, rewind_active, save, load, sleep_rewind, vsync;
    logic [1:0]  savestate_number;
    logic        request_savestate, request_loadstate, request_busy;
    logic [31:0] request_address;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic        busy_hold = 1'b0;
    logic        prev_s = 1'b0, prev_l = 1'b0;

    always #5 clk = ~clk;

    gb_statemanager_rewind #(
        .REWIND_DEPTH(4), .SLOT_SIZE(32'h100), .REWIND_ADDR(32'h1000),
        .SAVE_ADDR(32'h0), .FRAME_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .rewind_on(rewind_on), .rewind_active(rewind_active),
        .savestate_number(savestate_number), .save(save), .load(load),
        .sleep_rewind(sleep_rewind), .vsync(vsync),
        .request_savestate(request_savestate), .request_loadstate(request_loadstate),
        .request_address(request_address), .request_busy(request_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // State-engine responder: one-cycle busy ack, or held busy when busy_hold is set.
    always @(negedge clk) begin
        if (reset) request_busy = 1'b0;
        else if (busy_hold) begin
            if (request_savestate || request_loadstate) request_busy = 1'b1;
        end else request_busy = (request_savestate || request_loadstate) && !request_busy;
    end

    // Monitor: each new request pops one scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            prev_s = 1'b0;
            prev_l = 1'b0;
        end else begin
            if ((request_savestate && !prev_s) || (request_loadstate && !prev_l)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got save=%0b load=%0b addr=0x%0h expected none",
                             request_savestate, request_loadstate, request_address);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("req_both", 32'(request_savestate & request_loadstate), 32'd0);
                    chk("req_kind_load", 32'(request_loadstate), 32'(e[32]));
                    chk("req_addr", request_address, e[31:0]);
                end
            end
            prev_s = request_savestate;
            prev_l = request_loadstate;
        end
    end

    task automatic push(input logic is_load, input logic [31:0] addr);
        exp_q.push_back({is_load, addr});
    endtask

    task automatic edges(input int n, input logic chk_sleep);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            repeat (10) @(negedge clk);
            vsync = 1'b0;
            repeat (10) @(negedge clk);
            if (chk_sleep) chk("sleep_rewind", 32'(sleep_rewind), 32'd1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; rewind_on = 1'b0; save = 1'b0; load = 1'b0;
        vsync = 1'b0; savestate_number = 2'd0; request_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(rewind_active), 32'd0);
        chk("rst_sleep", 32'(sleep_rewind), 32'd0);
        chk("rst_req_save", 32'(request_savestate), 32'd0);
        chk("rst_req_load", 32'(request_loadstate), 32'd0);
        chk("rst_addr", request_address, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Two captures from four frame ticks.
        push(0, 32'h1000); push(0, 32'h1100);
        edges(4, 1'b0);
        drain();
        chk("t038_count", 32'(dut.count_q), 32'd2);
        chk("t038_wrptr", 32'(dut.wr_ptr_q), 32'd2);

        // Ring wraps, count saturates.
        do_reset();
        push(0, 32'h1000); push(0, 32'h1100); push(0, 32'h1200);
        push(0, 32'h1300); push(0, 32'h1000); push(0, 32'h1100);
        edges(12, 1'b0);
        drain();
        chk("t039_count", 32'(dut.count_q), 32'd4);
        chk("t039_wrptr", 32'(dut.wr_ptr_q), 32'd2);

        // Rewind walks back newest-first, then stalls with sleep held.
        rewind_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("t040_active", 32'(rewind_active), 32'd1);
        push(1, 32'h1100); push(1, 32'h1000); push(1, 32'h1300); push(1, 32'h1200);
        edges(10, 1'b1);
        drain();
        chk("t040_count", 32'(dut.count_q), 32'd0);
        chk("t040_wrptr", 32'(dut.wr_ptr_q), 32'd2);
        rewind_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("t040_release", 32'(sleep_rewind), 32'd0);

        // Refill two entries, then manual save/load.
        push(0, 32'h1200); push(0, 32'h1300);
        edges(4, 1'b0);
        drain();
        chk("t041_count_pre", 32'(dut.count_q), 32'd2);
        savestate_number = 2'd3; save = 1'b1; load = 1'b1;
        @(negedge clk);
        save = 1'b0; load = 1'b0; savestate_number = 2'd0;
        push(0, 32'h300);
        repeat (20) @(negedge clk);
        drain();
        chk("t041_count_save", 32'(dut.count_q), 32'd2);
        savestate_number = 2'd1; load = 1'b1;
        @(negedge clk);
        load = 1'b0; savestate_number = 2'd2;
        push(1, 32'h100);
        repeat (20) @(negedge clk);
        drain();
        chk("t041_count_load", 32'(dut.count_q), 32'd0);
        chk("t041_wrptr", 32'(dut.wr_ptr_q), 32'd0);

        // Reset while stuck in WAIT_DONE; second event there must be dropped.
        busy_hold = 1'b1;
        push(0, 32'h1000);
        edges(4, 1'b0);
        chk("t042_drained", 32'(exp_q.size()), 32'd0);
        chk("t042_wait_state", 32'(dut.state_q), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("t042_req_save", 32'(request_savestate), 32'd0);
        chk("t042_req_load", 32'(request_loadstate), 32'd0);
        chk("t042_addr", request_address, 32'd0);
        chk("t042_count", 32'(dut.count_q), 32'd0);
        chk("t042_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        busy_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push(0, 32'h1000);
        edges(2, 1'b0);
        drain();
        chk("t042_count_after", 32'(dut.count_q), 32'd1);
        chk("t042_wrptr_after", 32'(dut.wr_ptr_q), 32'd1);

        repeat (30) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
